// File: rtl/slapfight_prom_pkg.sv
// Shared layout of the Slap Fight colour/sprite PROM images inside the download stream.
// Offsets are relative to the first PROM byte of the download.
package slapfight_prom_pkg;

    typedef enum logic [2:0] {
        PROM14, PROM15, PROM16, PROM17, PROM18, PROM19, PROM20, PROM21
    } prom_id_t;

    localparam int NUM_PROMS = 8;

    localparam logic [10:0] PROM_OFS [NUM_PROMS] = '{
        11'h000, 11'h100, 11'h200, 11'h300, 11'h400, 11'h420, 11'h520, 11'h620
    };

    localparam logic [8:0] PROM_SIZE [NUM_PROMS] = '{
        9'd256, 9'd256, 9'd256, 9'd256, 9'd32, 9'd256, 9'd256, 9'd256
    };

    localparam logic [10:0] PROM_TOTAL = 11'd1824;

    typedef enum logic [1:0] {
        ST_IDLE, ST_LOAD, ST_DONE, ST_ERROR
    } state_t;

    // Only PROM18 carries a full byte; the others are 4-bit parts.
    function automatic logic keeps_high_nibble(input int idx);
        return idx == int'(PROM18);
    endfunction

endpackage

// File: rtl/prom_region_decode.sv
// Maps a download offset onto one PROM: one-hot select, local address,
// whether the high nibble is kept, and whether the offset hits any PROM.
module prom_region_decode
    import slapfight_prom_pkg::*;
(
    input  logic [24:0] offset,
    output logic [7:0]  sel,
    output logic [7:0]  local_addr,
    output logic        keep_high,
    output logic        in_range
);

    logic [7:0] hit;
    logic [7:0] rel_lo [NUM_PROMS];

    generate
        for (genvar gi = 0; gi < NUM_PROMS; gi++) begin : g_region
            assign hit[gi] = (offset >= 25'(PROM_OFS[gi])) &&
                             (offset <  25'(PROM_OFS[gi]) + 25'(PROM_SIZE[gi]));
            // Every region is at most 256 bytes, so the low byte of the difference suffices.
            assign rel_lo[gi] = offset[7:0] - PROM_OFS[gi][7:0];
        end
    endgenerate

    always_comb begin
        local_addr = '0;
        keep_high  = 1'b0;
        for (int i = 0; i < NUM_PROMS; i++) begin
            if (hit[i]) begin
                local_addr = local_addr | rel_lo[i];
                keep_high  = keep_high | keeps_high_nibble(i);
            end
        end
    end

    assign sel      = hit;
    assign in_range = |hit;

endmodule

// File: rtl/prom_loader.sv
// Captures PROM bytes from the ROM download stream and writes them to the
// eight Slap Fight PROMs, tracking completeness and a running checksum.
module prom_loader
    import slapfight_prom_pkg::*;
#(
    parameter logic [24:0] PROM_BASE = 25'h30000,
    parameter logic [7:0]  DL_INDEX  = 8'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dl_en,
    input  logic [7:0]  dl_index,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic [7:0]  prom_we,
    output logic [7:0]  prom_addr,
    output logic [7:0]  prom_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] checksum
);

    state_t      state_reg;
    logic        dl_en_reg;
    logic [10:0] count_reg;
    logic [10:0] count_next;
    logic [15:0] checksum_next;

    logic [24:0] offset;
    logic [7:0]  sel;
    logic [7:0]  local_addr;
    logic        keep_high;
    logic        in_range;
    logic        index_ok;
    logic        start;
    logic        fall;
    logic        accept;
    logic [7:0]  masked_data;

    assign offset = dl_addr - PROM_BASE;

    prom_region_decode u_decode (
        .offset     (offset),
        .sel        (sel),
        .local_addr (local_addr),
        .keep_high  (keep_high),
        .in_range   (in_range)
    );

    assign index_ok    = (dl_index == DL_INDEX);
    assign start       = dl_en && !dl_en_reg && index_ok && (state_reg != ST_LOAD);
    assign fall        = !dl_en && dl_en_reg;
    // A strobe arriving with the opening edge belongs to the new session.
    assign accept      = dl_wr && dl_en && index_ok && (dl_addr >= PROM_BASE) && in_range &&
                         ((state_reg == ST_LOAD) || start);
    assign masked_data = keep_high ? dl_data : {4'h0, dl_data[3:0]};

    always_comb begin
        count_next    = start ? 11'd0 : count_reg;
        checksum_next = start ? 16'd0 : checksum;
        if (accept) begin
            if (count_next < PROM_TOTAL) begin
                count_next = count_next + 11'd1;
            end
            checksum_next = checksum_next + 16'(masked_data);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            // Tracking the live level keeps a still-high dl_en from looking like a new session.
            dl_en_reg <= dl_en;
            count_reg <= '0;
            prom_we   <= '0;
            prom_addr <= '0;
            prom_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            checksum  <= '0;
        end else begin
            dl_en_reg <= dl_en;
            count_reg <= count_next;
            checksum  <= checksum_next;
            prom_we   <= accept ? sel : 8'h00;
            if (accept) begin
                prom_addr <= local_addr;
                prom_data <= masked_data;
            end
            case (state_reg)
                ST_LOAD: begin
                    if (fall) begin
                        busy <= 1'b0;
                        if (count_reg == PROM_TOTAL) begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= ST_ERROR;
                            err       <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_reg <= ST_LOAD;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/prom_loader.md
PROM_LOADER -- requirements
Module: prom_loader

Interface
REQ-001 SHALL have parameter PROM_BASE, default 25'h30000, the download byte address of the first PROM byte.
REQ-002 SHALL have parameter DL_INDEX, default 8'd0, the download index that carries the PROM images.
REQ-003 SHALL have port clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port dl_en  in  1  download session active.
REQ-006 SHALL have port dl_index  in  8  selects which image the session carries.
REQ-007 SHALL have port dl_wr  in  1  one-cycle byte strobe.
REQ-008 SHALL have port dl_addr  in  25  byte address of the strobed byte.
REQ-009 SHALL have port dl_data  in  8  strobed byte.
REQ-010 SHALL have port prom_we  out  8  one-hot write enable; bit 0..7 = PROM 14,15,16,17,18,19,20,21.
REQ-011 SHALL have port prom_addr  out  8  PROM-local write address.
REQ-012 SHALL have port prom_data  out  8  write data.
REQ-013 SHALL have port busy  out  1  a session is in progress.
REQ-014 SHALL have port done  out  1  all 1824 PROM bytes were received and the session closed.
REQ-015 SHALL have port err  out  1  the session closed before all PROM bytes were received.
REQ-016 SHALL have port checksum  out  16  modulo-2^16 sum of written bytes after masking.

Function
REQ-017 SHALL map offset o = dl_addr - PROM_BASE as follows:
  - 0x000-0x3FF -> PROM14..17, 256 bytes each.
  - 0x400-0x41F -> PROM18, 32 bytes.
  - 0x420-0x51F -> PROM19; 0x520-0x61F -> PROM20; 0x620-0x71F -> PROM21.
REQ-018 SHALL ignore any strobe with dl_addr < PROM_BASE or o >= 0x720: no prom_we, no count, no checksum update.
REQ-019 SHALL ignore strobes when dl_en=0 or dl_index != DL_INDEX.
REQ-020 SHALL register each accepted strobe and drive prom_we, prom_addr and prom_data exactly one cycle after dl_wr; prom_we is high for one cycle.
REQ-021 SHALL set prom_addr to the byte's local offset within its PROM; for PROM18, prom_addr[7:5] = 0.
REQ-022 SHALL mask prom_data[7:4] to 0 for every PROM except PROM18, which passes all 8 bits.
REQ-023 SHALL implement FSM IDLE -> LOAD on rising dl_en with a matching index; this clears the count, checksum, done and err.
REQ-024 SHALL transition LOAD -> DONE on dl_en fall when count = 1824, and LOAD -> ERROR on dl_en fall when count < 1824.
REQ-025 SHALL transition DONE or ERROR -> LOAD on the next matching rising dl_en.
REQ-026 SHALL use an 11-bit byte count that increments per accepted strobe and saturates at 1824; rewriting the same address still counts.
REQ-027 SHALL hold busy=1 only in LOAD, done=1 only in DONE, and err=1 only in ERROR.
REQ-028 SHALL, if dl_wr coincides with the dl_en falling edge, not accept that byte and still decide DONE/ERROR from the prior count.
REQ-029 SHALL let the final accepted strobe's prom_we complete even if dl_en falls in the following cycle.
REQ-030 SHALL not stall the source: a strobe on every cycle is accepted back-to-back.

Reset
REQ-031 SHALL, when reset_n=0 on a clock edge, enter IDLE and clear prom_we, prom_addr, prom_data, busy, done, err, checksum and count to 0.
REQ-032 SHALL, on reset mid-LOAD, abandon the session with no further writes; a new rising dl_en is required to reload.

Structure
REQ-033 SHALL place the PROM enumeration, the base offsets and sizes (0x000,0x100,0x200,0x300,0x400,0x420,0x520,0x620; sizes 256/32) and the 1824 total in the shared package slapfight_prom_pkg.
REQ-034 SHALL implement the offset-to-PROM decode (offset -> one-hot select, local address, nibble-mask flag, in-range) as the single combinational sub-module prom_region_decode.

Verification
REQ-035 Full load: stream all 1824 bytes with PROM_BASE offsets -> 1824 one-cycle prom_we pulses, each one cycle after dl_wr; done=1, err=0 after dl_en falls.
REQ-036 Masking: byte 0xA8 at o=0x000 -> prom_we=8'h01, prom_data=0x08; byte 0xC1 at o=0x412 -> prom_we=8'h10, prom_addr=0x12, prom_data=0xC1.
REQ-037 Boundaries: o=0x41F -> PROM18 addr 0x1F; o=0x420 -> PROM19 addr 0x00; o=0x720 and dl_addr=PROM_BASE-1 -> no prom_we, count unchanged.
REQ-038 Short session: 1000 bytes then dl_en falls -> err=1, done=0; a new full session then yields done=1, err=0.
REQ-039 Wrong index: dl_index=1 with 1824 strobes -> no prom_we, state stays IDLE.
REQ-040 Reset mid-load: reset_n low after 500 bytes -> all outputs 0 next cycle and no writes while dl_wr continues.
